// File: rtl/cbm2_bus_pkg.sv
// CBM-II bus sequencer shared types.
// Target classes, FSM states, I/O select indices and RAM map helper.
package cbm2_bus_pkg;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_RAM  = 2'd1,
        TGT_ROM  = 2'd2,
        TGT_IO   = 2'd3
    } tgt_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ACCESS = 2'd2,
        S_ACK    = 2'd3
    } state_e;

    localparam int IO_COLRAM = 0;
    localparam int IO_VIDEO  = 1;
    localparam int IO_SID    = 2;
    localparam int IO_IPCIA  = 3;
    localparam int IO_CIA    = 4;
    localparam int IO_ACIA   = 5;
    localparam int IO_TPI1   = 6;
    localparam int IO_TPI2   = 7;

    // B2 machines start RAM at segment 1, P2 machines at segment 0.
    function automatic logic seg_ram_present(
        input logic       model,
        input logic [1:0] ram_size,
        input logic [7:0] seg
    );
        logic r;
        r = 1'b0;
        unique case (ram_size)
            2'd0:    r = model ? (seg >= 8'd1 && seg <= 8'd2) : (seg <= 8'd1);
            2'd1:    r = model ? (seg >= 8'd1 && seg <= 8'd4) : (seg <= 8'd3);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cbm2_bus_sequencer_addr_decode.sv
// Combinational {segment, address} decode into target class and I/O select.
// Shared with the video fetch paths.
import cbm2_bus_pkg::*;

module cbm2_addr_decode (
    input  logic [23:0] i_addr,
    input  logic        i_model,
    input  logic [1:0]  i_ram_size,
    input  logic        i_ipc_en,
    output tgt_e        o_cls,
    output logic [7:0]  o_io_sel
);

    logic [7:0]  w_seg;
    logic [15:0] w_a;

    assign w_seg = i_addr[23:16];
    assign w_a   = i_addr[15:0];

    always_comb begin
        o_cls    = TGT_NONE;
        o_io_sel = 8'h00;
        if (w_seg == 8'h0F) begin
            case (w_a[15:12])
                4'h0: if (!w_a[11] || i_ipc_en) o_cls = TGT_RAM;
                4'h8, 4'h9, 4'hA, 4'hB,
                4'hE, 4'hF: o_cls = TGT_ROM;
                4'hC: if (!i_model) o_cls = TGT_ROM;
                4'hD: begin
                    case (w_a[11:8])
                        4'h0, 4'h1, 4'h2, 4'h3: o_cls = TGT_RAM;
                        // P2 colour RAM shadows ordinary RAM here
                        4'h4, 4'h5, 4'h6, 4'h7: begin
                            if (!i_model) begin
                                o_cls = TGT_RAM;
                                o_io_sel[IO_COLRAM] = 1'b1;
                            end
                        end
                        4'h8: begin
                            o_cls = TGT_IO;
                            o_io_sel[IO_VIDEO] = 1'b1;
                        end
                        4'hA: begin
                            o_cls = TGT_IO;
                            o_io_sel[IO_SID] = 1'b1;
                        end
                        4'hB: begin
                            if (i_ipc_en) begin
                                o_cls = TGT_IO;
                                o_io_sel[IO_IPCIA] = 1'b1;
                            end
                        end
                        4'hC: begin
                            o_cls = TGT_IO;
                            o_io_sel[IO_CIA] = 1'b1;
                        end
                        4'hD: begin
                            o_cls = TGT_IO;
                            o_io_sel[IO_ACIA] = 1'b1;
                        end
                        4'hE: begin
                            o_cls = TGT_IO;
                            o_io_sel[IO_TPI1] = 1'b1;
                        end
                        4'hF: begin
                            o_cls = TGT_IO;
                            o_io_sel[IO_TPI2] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (seg_ram_present(i_model, i_ram_size, w_seg)) begin
            o_cls = TGT_RAM;
        end
    end

endmodule

// File: rtl/cbm2_bus_sequencer.sv
// Multi-master CBM-II system bus sequencer: arbitration, decode,
// wait-state insertion and per-master read data holding.
import cbm2_bus_pkg::*;

module cbm2_bus_sequencer #(
    parameter int NUM_M   = 2,
    parameter int ROM_LAT = 1,
    parameter int PRIO0   = 1
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               model,
    input  logic [1:0]         ramSize,
    input  logic               ipcEn,
    input  logic [NUM_M-1:0]   m_req,
    input  logic [NUM_M-1:0]   m_we,
    input  logic [NUM_M*24-1:0] m_addr,
    input  logic [NUM_M*8-1:0] m_wdata,
    output logic [NUM_M-1:0]   m_ack,
    output logic [NUM_M*8-1:0] m_rdata,
    output logic [23:0]        sysAddr,
    output logic               sysWe,
    output logic [7:0]         sysWdata,
    output logic               ram_req,
    input  logic               ram_ack,
    input  logic [7:0]         ramData,
    output logic               rom_cs,
    input  logic [7:0]         romData,
    output logic [7:0]         io_sel,
    input  logic [63:0]        ioData
);

    state_e              r_state;
    logic [1:0]          r_rr;
    logic [1:0]          r_gnt;
    logic [23:0]         r_addr;
    logic                r_we;
    logic [7:0]          r_wdata;
    tgt_e                r_cls;
    logic [1:0]          r_cnt;
    logic [7:0]          r_data;
    logic                r_cap;
    logic [NUM_M-1:0]    r_ack;
    logic [NUM_M*8-1:0]  r_rdata;
    logic [23:0]         r_sys_addr;
    logic                r_sys_we;
    logic [7:0]          r_sys_wdata;
    logic                r_ram_req;
    logic                r_rom_cs;
    logic [7:0]          r_io_sel;

    logic                w_found;
    logic                w_prio;
    logic [1:0]          w_gnt;
    logic [2:0]          w_sum;
    logic [23:0]         w_addr;
    logic                w_we;
    logic [7:0]          w_wdata;
    logic [7:0]          w_cur;
    logic [7:0]          w_io_byte;
    tgt_e                w_cls;
    logic [7:0]          w_io_dec;

    assign m_ack    = r_ack;
    assign m_rdata  = r_rdata;
    assign sysAddr  = r_sys_addr;
    assign sysWe    = r_sys_we;
    assign sysWdata = r_sys_wdata;
    assign ram_req  = r_ram_req;
    assign rom_cs   = r_rom_cs;
    assign io_sel   = r_io_sel;

    // Master 0 may pre-empt the rotation; otherwise scan from r_rr.
    always_comb begin
        w_found = 1'b0;
        w_prio  = 1'b0;
        w_gnt   = 2'd0;
        w_sum   = 3'd0;
        if (PRIO0 != 0 && m_req[0]) begin
            w_found = 1'b1;
            w_prio  = 1'b1;
        end else begin
            for (int k = 0; k < NUM_M; k++) begin
                w_sum = {1'b0, r_rr} + 3'(k);
                if (w_sum >= 3'(NUM_M)) w_sum = w_sum - 3'(NUM_M);
                for (int j = 0; j < NUM_M; j++) begin
                    if (!w_found && w_sum[1:0] == 2'(j) && m_req[j]) begin
                        w_found = 1'b1;
                        w_gnt   = 2'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        w_addr  = 24'h0;
        w_we    = 1'b0;
        w_wdata = 8'h00;
        w_cur   = 8'h00;
        for (int k = 0; k < NUM_M; k++) begin
            if (w_gnt == 2'(k)) begin
                w_addr  = m_addr[k*24 +: 24];
                w_we    = m_we[k];
                w_wdata = m_wdata[k*8 +: 8];
            end
            if (r_gnt == 2'(k)) w_cur = r_rdata[k*8 +: 8];
        end
    end

    always_comb begin
        w_io_byte = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (r_io_sel[k]) w_io_byte = w_io_byte | ioData[k*8 +: 8];
        end
    end

    cbm2_addr_decode u_dec (
        .i_addr     (r_addr),
        .i_model    (model),
        .i_ram_size (ramSize),
        .i_ipc_en   (ipcEn),
        .o_cls      (w_cls),
        .o_io_sel   (w_io_dec)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr        <= 2'd0;
            r_gnt       <= 2'd0;
            r_addr      <= 24'h0;
            r_we        <= 1'b0;
            r_wdata     <= 8'h00;
            r_cls       <= TGT_NONE;
            r_cnt       <= 2'd0;
            r_data      <= 8'h00;
            r_cap       <= 1'b0;
            r_ack       <= '0;
            r_rdata     <= '1;
            r_sys_addr  <= 24'h0;
            r_sys_we    <= 1'b0;
            r_sys_wdata <= 8'h00;
            r_ram_req   <= 1'b0;
            r_rom_cs    <= 1'b0;
            r_io_sel    <= 8'h00;
        end else begin
            r_ack <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt;
                        r_addr  <= w_addr;
                        r_we    <= w_we;
                        r_wdata <= w_wdata;
                        r_state <= S_DECODE;
                        if (!w_prio) begin
                            r_rr <= (w_gnt == 2'(NUM_M - 1)) ? 2'd0 : w_gnt + 2'd1;
                        end
                    end
                end
                S_DECODE: begin
                    r_cls       <= w_cls;
                    r_cnt       <= 2'd0;
                    r_cap       <= 1'b0;
                    r_sys_addr  <= r_addr;
                    r_sys_we    <= r_we;
                    r_sys_wdata <= r_wdata;
                    r_ram_req   <= (w_cls == TGT_RAM);
                    r_rom_cs    <= (w_cls == TGT_ROM);
                    r_io_sel    <= w_io_dec;
                    r_state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    unique case (r_cls)
                        TGT_RAM: begin
                            if (r_ram_req && ram_ack) begin
                                r_data  <= ramData;
                                r_cap   <= !r_we;
                                r_state <= S_ACK;
                            end
                        end
                        TGT_ROM: begin
                            if (r_cnt == 2'(ROM_LAT - 1)) begin
                                r_data  <= romData;
                                r_cap   <= !r_we;
                                r_state <= S_ACK;
                            end else begin
                                r_cnt <= r_cnt + 2'd1;
                            end
                        end
                        TGT_IO: begin
                            // colour RAM is only a nibble wide
                            r_data  <= r_io_sel[IO_COLRAM] ?
                                       {w_cur[7:4], w_io_byte[3:0]} : w_io_byte;
                            r_cap   <= !r_we;
                            r_state <= S_ACK;
                        end
                        default: begin
                            r_cap   <= 1'b0;
                            r_state <= S_ACK;
                        end
                    endcase
                    if (r_cls != TGT_RAM || (r_ram_req && ram_ack)) begin
                        if (r_cls != TGT_ROM || r_cnt == 2'(ROM_LAT - 1)) begin
                            r_sys_addr  <= 24'h0;
                            r_sys_we    <= 1'b0;
                            r_sys_wdata <= 8'h00;
                            r_ram_req   <= 1'b0;
                            r_rom_cs    <= 1'b0;
                            r_io_sel    <= 8'h00;
                        end
                    end
                end
                S_ACK: begin
                    r_ack <= NUM_M'(4'd1 << r_gnt);
                    for (int k = 0; k < NUM_M; k++) begin
                        if (r_cap && r_gnt == 2'(k)) r_rdata[k*8 +: 8] <= r_data;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
